// File: rtl/timer_pkg.sv
// Shared definitions for multi_channel_timer and its channel sub-module.
//   Register offsets: relative to BASE_ADDR of the bus window.
//   Control bit indices: the layout of each channel's control byte.
//   MAX_CH: the largest supported channel count.
package timer_pkg;

  localparam int unsigned MAX_CH = 4;

  localparam logic [7:0] TS_LO   = 8'd0;
  localparam logic [7:0] TS_HI   = 8'd1;
  localparam logic [7:0] CLR     = 8'd2;
  localparam logic [7:0] PEND    = 8'd3;
  localparam logic [7:0] CH_BASE = 8'd4;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_RESTART = 2;

  // Read-back image of a channel control byte; RESTART is write-only and reads 0.
  function automatic logic [7:0] ctrl_byte(input logic en, input logic oneshot);
    logic [7:0] b;
    b = 8'h00;
    b[CTRL_EN]      = en;
    b[CTRL_ONESHOT] = oneshot;
    return b;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel.
//   CLK, RESET    : system clock, asynchronous active-high reset
//   tick          : one-cycle prescaler pulse
//   clear_reload  : window clear; reloads the counter when enabled
//   period_we     : period write (also loads the counter)
//   ctrl_we       : control write (EN/ONESHOT from wdata)
//   restart       : control write with RESTART set
//   wdata         : bus write data
//   period, en, oneshot : register state for read-back
//   expire        : one-cycle pulse on the tick where the count runs out
module timer_channel
  import timer_pkg::*;
#(
  parameter logic [7:0] INIT_PERIOD = 8'd0,
  parameter logic       INIT_EN     = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       tick,
  input  logic       clear_reload,
  input  logic       period_we,
  input  logic       ctrl_we,
  input  logic       restart,
  input  logic [7:0] wdata,
  output logic [7:0] period,
  output logic       en,
  output logic       oneshot,
  output logic       expire
);

  logic [7:0] period_q, period_d;
  logic [7:0] count_q, count_d;
  logic       en_q, en_d;
  logic       os_q, os_d;
  logic       load;
  logic       active;
  logic [7:0] load_val;

  // Any bus-side load takes priority over the tick action in the same cycle.
  assign load = period_we | restart | (ctrl_we & wdata[CTRL_EN] & ~en_q) |
                (clear_reload & en_q);
  assign load_val = period_we ? wdata : period_q;
  // A zero period freezes the channel regardless of EN.
  assign active = tick & en_q & (period_q != 8'd0);
  assign expire = active & (count_q == 8'd1) & ~load;

  always_comb begin
    period_d = period_q;
    count_d  = count_q;
    en_d     = en_q;
    os_d     = os_q;
    if (period_we) period_d = wdata;
    if (ctrl_we) begin
      en_d = wdata[CTRL_EN];
      os_d = wdata[CTRL_ONESHOT];
    end
    if (load) begin
      count_d = load_val;
    end else if (active) begin
      if (count_q == 8'd1) begin
        if (os_q) begin
          count_d = 8'd0;
          if (!ctrl_we) en_d = 1'b0;
        end else begin
          count_d = period_q;
        end
      end else begin
        count_d = count_q - 8'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      period_q <= INIT_PERIOD;
      count_q  <= INIT_PERIOD;
      en_q     <= INIT_EN;
      os_q     <= 1'b0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
      en_q     <= en_d;
      os_q     <= os_d;
    end
  end

  assign period  = period_q;
  assign en      = en_q;
  assign oneshot = os_q;

endmodule

// File: rtl/multi_channel_timer.sv
// Bus-mapped multi-channel timer: shared prescaler, 16-bit timestamp with coherent
// high-byte shadow, NUM_CH down-counting channels and a pending/interrupt register.
//   CLK, RESET          : system clock, asynchronous active-high reset
//   BUS_DATA            : 8-bit bidirectional processor data bus
//   BUS_ADDR, BUS_WE    : processor address and single-cycle write strobe
//   BUS_INTERRUPT_RAISE : high while any pending bit is set
//   BUS_INTERRUPT_ACK   : clears all pending bits
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR   = 8'hF0,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CLK_DIV     = 100000,
  parameter logic [7:0]  INIT_RATE   = 8'd100,
  parameter logic        INIT_ENABLE = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int unsigned PW       = $clog2(CLK_DIV);
  localparam logic [7:0]  WIN_SIZE = 8'(CH_BASE + 8'(2 * NUM_CH));

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..MAX_CH");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("CLK_DIV must be at least 2");
  end

  logic [PW-1:0]     presc_q, presc_d;
  logic [15:0]       ts_q, ts_d;
  logic [7:0]        shadow_q, shadow_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic              rd_valid_q;
  logic [7:0]        rd_data_q, rd_mux;

  logic [7:0] offset;
  logic       in_win, wr_en, rd_en, clr_we, tick;
  logic [NUM_CH-1:0] w1c_mask;

  logic [7:0]        ch_period [NUM_CH];
  logic [NUM_CH-1:0] ch_en, ch_os, ch_expire;
  logic [NUM_CH-1:0] per_we, ctl_we, restart;

  // Unsigned wrap makes addresses below BASE_ADDR fall outside the window.
  assign offset = BUS_ADDR - BASE_ADDR;
  assign in_win = offset < WIN_SIZE;
  assign wr_en  = in_win & BUS_WE;
  assign rd_en  = in_win & ~BUS_WE;
  assign clr_we = wr_en & (offset == CLR);
  assign tick   = presc_q == PW'(CLK_DIV - 1);
  assign w1c_mask = (wr_en && offset == PEND) ? BUS_DATA[NUM_CH-1:0] : '0;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [7:0] PER_OFF = 8'(CH_BASE + 8'(2 * c));

    assign per_we[c]  = wr_en & (offset == PER_OFF);
    assign ctl_we[c]  = wr_en & (offset == PER_OFF + 8'd1);
    assign restart[c] = ctl_we[c] & BUS_DATA[CTRL_RESTART];

    timer_channel #(
      .INIT_PERIOD (c == 0 ? INIT_RATE : 8'd0),
      .INIT_EN     (c == 0 ? INIT_ENABLE : 1'b0)
    ) u_ch (
      .CLK          (CLK),
      .RESET        (RESET),
      .tick         (tick),
      .clear_reload (clr_we),
      .period_we    (per_we[c]),
      .ctrl_we      (ctl_we[c]),
      .restart      (restart[c]),
      .wdata        (BUS_DATA),
      .period       (ch_period[c]),
      .en           (ch_en[c]),
      .oneshot      (ch_os[c]),
      .expire       (ch_expire[c])
    );
  end

  always_comb begin
    rd_mux = 8'h00;
    if (offset == TS_LO)      rd_mux = ts_q[7:0];
    else if (offset == TS_HI) rd_mux = shadow_q;
    else if (offset == PEND)  rd_mux = 8'(pend_q);
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (offset == 8'(CH_BASE + 8'(2 * c)))     rd_mux = ch_period[c];
      if (offset == 8'(CH_BASE + 8'(2 * c + 1))) rd_mux = ctrl_byte(ch_en[c], ch_os[c]);
    end
  end

  always_comb begin
    presc_d  = presc_q;
    ts_d     = ts_q;
    shadow_d = shadow_q;
    if (clr_we) begin
      presc_d  = '0;
      ts_d     = 16'h0000;
      shadow_d = 8'h00;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) ts_d = ts_q + 16'd1;
      // Low-byte read freezes the high byte for a coherent 16-bit read.
      if (rd_en && offset == TS_LO) shadow_d = ts_q[15:8];
    end
    // New expiries win over ACK and W1C in the same cycle.
    pend_d = (pend_q & ~{NUM_CH{BUS_INTERRUPT_ACK}} & ~w1c_mask) | ch_expire;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc_q    <= '0;
      ts_q       <= 16'h0000;
      shadow_q   <= 8'h00;
      pend_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
    end else begin
      presc_q    <= presc_d;
      ts_q       <= ts_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      rd_valid_q <= rd_en;
      rd_data_q  <= rd_mux;
    end
  end

  assign BUS_DATA            = rd_valid_q ? rd_data_q : 8'hzz;
  assign BUS_INTERRUPT_RAISE = |pend_q;

endmodule

// File: tb/tb_multi_channel_timer.sv
module tb_multi_channel_timer;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned NUM_CH  = 4;
  localparam logic [7:0]  BASE    = 8'hF0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bus_addr = 8'h00;
  logic       bus_we = 1'b0;
  logic       ack = 1'b0;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_drv = 8'h00;
  logic       raise;
  // Pulled-up bus: a released bus reads 8'hFF.
  tri1  [7:0] bus_data;

  assign bus_data = tb_oe ? tb_drv : 8'hzz;

  multi_channel_timer #(
    .BASE_ADDR   (BASE),
    .NUM_CH      (NUM_CH),
    .CLK_DIV     (CLK_DIV),
    .INIT_RATE   (8'd100),
    .INIT_ENABLE (1'b1)
  ) dut (
    .CLK                 (clk),
    .RESET               (rst),
    .BUS_DATA            (bus_data),
    .BUS_ADDR            (bus_addr),
    .BUS_WE              (bus_we),
    .BUS_INTERRUPT_RAISE (raise),
    .BUS_INTERRUPT_ACK   (ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Channels are tracked as "absolute tick index of next expiry" rather than counters.
  int         m_presc, m_ticks, m_ts;
  logic [7:0] m_shadow;
  logic [3:0] m_pend;
  logic       m_rd_valid;
  logic [7:0] m_rd_data;
  logic       m_en [4];
  logic       m_os [4];
  logic [7:0] m_per [4];
  int         m_next [4];

  task automatic m_reset();
    m_presc = 0; m_ticks = 0; m_ts = 0; m_shadow = 8'h00; m_pend = 4'h0;
    m_rd_valid = 1'b0; m_rd_data = 8'h00;
    for (int c = 0; c < 4; c++) begin
      m_en[c] = (c == 0); m_os[c] = 1'b0;
      m_per[c] = (c == 0) ? 8'd100 : 8'd0;
      m_next[c] = (c == 0) ? 100 : 0;
    end
  endtask

  function automatic logic [7:0] m_reg(input int off);
    int c;
    if (off == 0) return m_ts[7:0];
    if (off == 1) return m_shadow;
    if (off == 3) return {4'h0, m_pend};
    if (off >= 4 && off < 4 + 2 * NUM_CH) begin
      c = (off - 4) / 2;
      if ((off % 2) == 0) return m_per[c];
      return {6'b0, m_os[c], m_en[c]};
    end
    return 8'h00;
  endfunction

  task automatic m_step();
    logic [7:0] o8;
    int         off, tidx;
    logic       tick, inwin, wr, rd;
    logic [3:0] load, expv, clr;
    logic [7:0] new_shadow;
    tick  = (m_presc == CLK_DIV - 1);
    tidx  = m_ticks + (tick ? 1 : 0);
    o8    = bus_addr - BASE;
    off   = int'(o8);
    inwin = off < 4 + 2 * NUM_CH;
    wr    = inwin && bus_we;
    rd    = inwin && !bus_we;
    m_rd_valid = rd;
    if (rd) m_rd_data = m_reg(off);
    new_shadow = (rd && off == 0) ? 8'((m_ts >> 8) & 255) : m_shadow;
    for (int c = 0; c < 4; c++) begin
      load[c] = wr && ((off == 4 + 2 * c) ||
                       (off == 5 + 2 * c && ((tb_drv[0] && !m_en[c]) || tb_drv[2])) ||
                       (off == 2 && m_en[c]));
      expv[c] = tick && m_en[c] && m_per[c] != 0 && m_next[c] == tidx && !load[c];
    end
    clr = ack ? 4'hF : 4'h0;
    if (wr && off == 3) clr = clr | tb_drv[3:0];
    m_pend = (m_pend & ~clr) | expv;
    for (int c = 0; c < 4; c++) begin
      if (expv[c]) begin
        if (m_os[c]) m_en[c] = 1'b0;
        else         m_next[c] = tidx + m_per[c];
      end
      if (wr && off == 4 + 2 * c) m_per[c] = tb_drv;
      if (wr && off == 5 + 2 * c) begin
        m_en[c] = tb_drv[0];
        m_os[c] = tb_drv[1];
      end
      if (load[c]) m_next[c] = tidx + m_per[c];
    end
    if (wr && off == 2) begin
      m_presc = 0; m_ts = 0; m_shadow = 8'h00;
    end else begin
      m_presc = tick ? 0 : m_presc + 1;
      if (tick) m_ts = (m_ts + 1) % 65536;
      m_shadow = new_shadow;
    end
    m_ticks = tidx;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!tb_oe) check("bus_data", bus_data, m_rd_valid ? m_rd_data : 8'hFF);
      check("raise", raise, |m_pend);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int off, input logic [7:0] d);
    bus_addr = BASE + 8'(off);
    bus_we = 1'b1; tb_oe = 1'b1; tb_drv = d;
    step();
    bus_we = 1'b0; tb_oe = 1'b0; bus_addr = 8'h00;
  endtask

  task automatic rd(input int off, output logic [7:0] v);
    bus_addr = BASE + 8'(off);
    step();
    bus_addr = 8'h00;
    v = bus_data;
    step();
  endtask

  task automatic check_rd(input string name, input int off, input logic [7:0] exp);
    logic [7:0] v;
    rd(off, v);
    check(name, v, exp);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic wait_raise(input int bound, output int e);
    bit found = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (raise) begin
        found = 1;
        break;
      end
    end
    if (!found) check("wait_raise_timeout", 0, 1);
    e = edge_cnt;
  endtask

  initial begin
    int         e, off, r;
    logic [7:0] lo, hi, d;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check_rd("rst_ts_lo", 0, 8'h00);
    check_rd("rst_pend", 3, 8'h00);
    check_rd("rst_ch0_period", 4, 8'h64);
    check_rd("rst_ch0_ctrl", 5, 8'h01);
    check_rd("rst_ch1_ctrl", 7, 8'h00);
    check_rd("rst_unmapped_clr", 2, 8'h00);

    // Channel 0 default: expiry at tick 100 and 200
    wait_raise(500, e);
    check("ch0_first_expiry_edge", e, 400);
    ack_pulse();
    check("ack_clears_raise", raise, 1'b0);
    wait_raise(500, e);
    check("ch0_second_expiry_edge", e, 800);
    ack_pulse();

    // One-shot channel 1
    wr(5, 8'h00);
    wr(6, 8'd3);
    wr(7, 8'h03);
    wait_raise(40, e);
    check_rd("oneshot_pend", 3, 8'h02);
    check_rd("oneshot_ctrl", 7, 8'h02);
    ack_pulse();
    repeat (80) step();
    check("oneshot_no_reexpire", raise, 1'b0);
    check_rd("oneshot_pend_after", 3, 8'h00);

    // Channels 2 and 3 loaded together by the clear
    wr(8, 8'd5);
    wr(9, 8'h01);
    wr(10, 8'd5);
    wr(11, 8'h01);
    wr(2, 8'h00);
    wait_raise(40, e);
    check_rd("pair_pend", 3, 8'h0C);
    wr(3, 8'h04);
    check_rd("w1c_pend", 3, 8'h08);
    check("w1c_raise_stays", raise, 1'b1);
    wr(9, 8'h00);
    wr(11, 8'h00);
    ack_pulse();
    check_rd("pair_cleanup", 3, 8'h00);

    // Expiry coincident with ACK: ch2 period 2 reloaded at clear edge E expires at E+8
    wr(8, 8'd2);
    wr(9, 8'h01);
    wr(2, 8'h00);
    repeat (7) step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_vs_expire_raise", raise, 1'b1);
    check_rd("ack_vs_expire_pend", 3, 8'h04);
    wr(9, 8'h00);
    ack_pulse();

    // Coherent timestamp read across 16'h01FF -> 16'h0200
    wr(2, 8'h00);
    repeat (2046) step();
    bus_addr = BASE + 8'd0;
    step();
    bus_addr = BASE + 8'd1;
    lo = bus_data;
    step();
    bus_addr = 8'h00;
    hi = bus_data;
    step();
    check("ts_lo_at_01ff", lo, 8'hFF);
    check("ts_shadow_at_01ff", hi, 8'h01);
    wr(2, 8'h00);
    check_rd("ts_after_clear", 0, 8'h00);
    check_rd("shadow_after_clear", 1, 8'h00);

    // Asynchronous reset mid-cycle while the bus is driven and RAISE is high
    wr(6, 8'd1);
    wr(7, 8'h01);
    wait_raise(20, e);
    bus_addr = BASE + 8'd3;
    step();
    bus_addr = 8'h00;
    check("pre_reset_drive", bus_data, 8'h02);
    #2 rst = 1'b1;
    #1;
    check("async_rst_raise", raise, 1'b0);
    check("async_rst_bus", bus_data, 8'hFF);
    step();
    rst = 1'b0;
    check_rd("post_rst_ts", 0, 8'h00);
    check_rd("post_rst_ch0_period", 4, 8'h64);
    check_rd("post_rst_ch0_ctrl", 5, 8'h01);
    check_rd("post_rst_ch1_period", 6, 8'h00);
    wait_raise(500, e);
    check("post_rst_ch0_expiry_edge", e, 400);
    ack_pulse();

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: step();
        3, 4: begin
          off = $urandom_range(0, 15);
          bus_addr = BASE + 8'(off);
          step();
          bus_addr = 8'h00;
          step();
        end
        5, 6, 7: begin
          off = $urandom_range(0, 11);
          // Channel and clear writes are kept off tick edges.
          if ((off == 2 || off >= 4) && m_presc == CLK_DIV - 1) begin
            step();
          end else begin
            if (off >= 4) d = (off % 2 == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 6));
            else          d = 8'($urandom_range(0, 255));
            wr(off, d);
          end
        end
        8: ack_pulse();
        default: wr(3, 8'($urandom_range(0, 15)));
      endcase
    end
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
